// File: rtl/median_wr_arbiter_pkg.sv
// Shared types and defaults for the median result-memory write arbiter.
// No logic of its own.
// No flow control of its own.
package median_arb_pkg;

    localparam int NCH                = 2;
    localparam int DW_DEFAULT         = 16;
    localparam int DEPTH_LOG2_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/median_wr_arbiter_if.sv
// Writer/reader-facing bundle of the median write arbiter.
// Pure wiring, no latency.
// req is a level held until ack; rd_done is a one-cycle release pulse.
interface median_wr_arbiter_if
    import median_arb_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) ();

    logic [NCH-1:0]         req_i;
    logic [NCH-1:0][DW-1:0] data_i;
    logic [NCH-1:0]         ack_o;
    logic                   wr_en_o;
    logic [DEPTH_LOG2:0]    wr_addr_o;
    logic [DW-1:0]          wr_data_o;
    logic [NCH-1:0]         frame_rdy_o;
    logic [NCH-1:0]         rd_done_i;
    logic                   busy_o;

    // Writer FSMs, reader and test drivers sit on this side.
    modport master (
        output req_i, data_i, rd_done_i,
        input  ack_o, wr_en_o, wr_addr_o, wr_data_o, frame_rdy_o, busy_o
    );

    // The arbiter itself.
    modport slave (
        input  req_i, data_i, rd_done_i,
        output ack_o, wr_en_o, wr_addr_o, wr_data_o, frame_rdy_o, busy_o
    );

endinterface

// File: rtl/median_wr_arbiter_rr_arb2.sv
// Two-way winner picker; a tie goes to the channel not served last (MEDIAN_ARB_FIXED_PRIO_EN: channel 0).
// Combinational pick; pointer updates one cycle after upd_i.
// No backpressure; the caller samples the pick only when it can accept it.
module rr_arb2 (
`ifndef MEDIAN_ARB_FIXED_PRIO_EN
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       upd_i,
    input  logic       upd_idx_i,
`endif
    input  logic [1:0] elig_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);

`ifndef MEDIAN_ARB_FIXED_PRIO_EN
    logic last_q;

    // Remember who completed the most recent write; reset favours channel 0 next.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_q <= 1'b1;
        end else if (upd_i) begin
            last_q <= upd_idx_i;
        end
    end

    // Single requester wins outright; on a tie the other channel than last_q wins.
    always_comb begin
        gnt_vld_o = |elig_i;
        gnt_idx_o = elig_i[1];
        if (elig_i == 2'b11) begin
            gnt_idx_o = ~last_q;
        end
    end
`else
    // Plain priority encoder: channel 0 always wins a tie.
    always_comb begin
        gnt_vld_o = |elig_i;
        gnt_idx_o = ~elig_i[0] & elig_i[1];
    end
`endif

endmodule

// File: rtl/median_wr_arbiter.sv
// Shares one result-RAM write port between two median writers; flags full regions (MEDIAN_ARB_FIXED_PRIO_EN selects fixed priority).
// Write strobe and ack two cycles after req is sampled in IDLE; one write per three cycles.
// A channel with frame_rdy set is ineligible until rd_done; the other channel keeps being served.
module median_wr_arbiter
    import median_arb_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    median_wr_arbiter_if.slave bus
);

    state_t                         state_q, state_d;
    logic                           winner_q, winner_d;
    logic [DEPTH_LOG2:0]            addr_q, addr_d;
    logic [DW-1:0]                  data_q, data_d;
    logic [NCH-1:0][DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]                 frame_rdy_q, frame_rdy_d;
    logic [NCH-1:0]                 elig;
    logic                           gnt_vld;
    logic                           gnt_idx;
    logic                           wr_fire;

    assign elig    = bus.req_i & ~frame_rdy_q;
    assign wr_fire = (state_q == WRITE);

    rr_arb2 u_arb (
`ifndef MEDIAN_ARB_FIXED_PRIO_EN
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .upd_i     (wr_fire),
        .upd_idx_i (winner_q),
`endif
        .elig_i    (elig),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    // Sequencer: pick and latch in IDLE, present address in GRANT, strobe in WRITE.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        addr_d   = addr_q;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    winner_d = gnt_idx;
                    data_d   = bus.data_i[gnt_idx];
                    addr_d   = {gnt_idx, cnt_q[gnt_idx]};
                    state_d  = GRANT;
                end
            end
            GRANT:   state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word counters and full flags; a set on the final write beats a same-cycle release.
    always_comb begin
        cnt_d       = cnt_q;
        frame_rdy_d = frame_rdy_q & ~bus.rd_done_i;
        if (wr_fire) begin
            cnt_d[winner_q] = cnt_q[winner_q] + DEPTH_LOG2'(1);
            if (&cnt_q[winner_q]) begin
                frame_rdy_d[winner_q] = 1'b1;
            end
        end
    end

    // State registers; reset discards any in-flight write and partial frames.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            winner_q    <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            frame_rdy_q <= '0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            frame_rdy_q <= frame_rdy_d;
        end
    end

    assign bus.wr_en_o     = wr_fire;
    assign bus.ack_o[0]    = wr_fire & ~winner_q;
    assign bus.ack_o[1]    = wr_fire & winner_q;
    assign bus.wr_addr_o   = addr_q;
    assign bus.wr_data_o   = data_q;
    assign bus.frame_rdy_o = frame_rdy_q;
    assign bus.busy_o      = (state_q != IDLE);

    a_ack_onehot:  assert property (@(posedge clk_i) disable iff (!rstn_i) $onehot0(bus.ack_o));
    a_wr_en_ack:   assert property (@(posedge clk_i) disable iff (!rstn_i) bus.wr_en_o == (|bus.ack_o));
    a_ack_not_rdy: assert property (@(posedge clk_i) disable iff (!rstn_i) (bus.ack_o & frame_rdy_q) == '0);
    a_req_held:    assert property (@(posedge clk_i) disable iff (!rstn_i)
                                    (state_q == GRANT) |-> bus.req_i[winner_q]);

endmodule

// File: tb/tb_median_wr_arbiter.sv
// Directed bench for median_wr_arbiter with a transaction-level reference model.
// Model predicts every output each cycle; literal checks pin model and latency.
// Channel drivers hold req until ack, then either drop it or present the next word.
module tb_median_wr_arbiter;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    median_wr_arbiter_if #(.DW(16), .DEPTH_LOG2(3)) bus ();

    median_wr_arbiter #(.DW(16), .DEPTH_LOG2(3)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          rem [2];
    logic [15:0] dat [2];
    logic [3:0]  last_addr [2];
    int          glog [$];

    assign bus.req_i  = {(rem[1] != 0), (rem[0] != 0)};
    assign bus.data_i = {dat[1], dat[0]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // ---------------- reference model ----------------
    // m_age counts edges since a write was chosen: 0 address shown, 1 strobe shown, 2 free.
    logic [1:0]  m_full;
    logic [2:0]  m_cnt [2];
    logic        m_last;
    logic        m_ch;
    int          m_age;
    logic [3:0]  m_addr;
    logic [15:0] m_data;
    logic [1:0]  m_el;

    task automatic m_reset();
        m_full   = 2'b00;
        m_cnt[0] = 3'd0;
        m_cnt[1] = 3'd0;
        m_last   = 1'b1;
        m_ch     = 1'b0;
        m_age    = 2;
        m_addr   = 4'd0;
        m_data   = 16'd0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk_i or negedge rstn_i);
            if (!rstn_i) begin
                m_reset();
            end else begin
                m_el   = bus.req_i & ~m_full;
                m_full = m_full & ~bus.rd_done_i;
                if (m_age == 0) begin
                    m_age = 1;
                end else if (m_age == 1) begin
                    if (m_cnt[m_ch] == 3'd7) m_full[m_ch] = 1'b1;
                    m_cnt[m_ch] = m_cnt[m_ch] + 3'd1;
                    m_last = m_ch;
                    m_age  = 2;
                end else if (m_el != 2'b00) begin
`ifdef MEDIAN_ARB_FIXED_PRIO_EN
                    m_ch = m_el[0] ? 1'b0 : 1'b1;
`else
                    m_ch = (m_el == 2'b11) ? ~m_last : m_el[1];
`endif
                    m_addr = {m_ch, m_cnt[m_ch]};
                    m_data = dat[m_ch];
                    m_age  = 0;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_i);
            check("wr_en",     bus.wr_en_o,     (m_age == 1));
            check("ack",       bus.ack_o,       (m_age == 1) ? (2'b01 << m_ch) : 2'b00);
            check("busy",      bus.busy_o,      (m_age < 2));
            check("frame_rdy", bus.frame_rdy_o, m_full);
            check("wr_addr",   bus.wr_addr_o,   m_addr);
            check("wr_data",   bus.wr_data_o,   m_data);
        end
    end

    // Channel drivers: on ack, consume one word and advance the data.
    initial begin
        forever begin
            @(negedge clk_i);
            for (int c = 0; c < 2; c++) begin
                if (rstn_i && bus.ack_o[c] && rem[c] > 0) begin
                    rem[c]--;
                    dat[c]++;
                    last_addr[c] = bus.wr_addr_o;
                    glog.push_back(c);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (!(rem[0] == 0 && rem[1] == 0 && !bus.busy_o) && k < 300) begin
            tick();
            k++;
        end
        if (k >= 300) timeout(name);
    endtask

    task automatic wait_ch1_done_ch0_full(input string name);
        int k = 0;
        while (!(rem[1] == 0 && bus.frame_rdy_o[0] && !bus.busy_o) && k < 300) begin
            tick();
            k++;
        end
        if (k >= 300) timeout(name);
    endtask

    task automatic wait_ch1_done(input string name);
        int k = 0;
        while (!(rem[1] == 0 && !bus.busy_o) && k < 300) begin
            tick();
            k++;
        end
        if (k >= 300) timeout(name);
    endtask

    task automatic wait_wr(input string name);
        int k = 0;
        while (!bus.wr_en_o && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) timeout(name);
    endtask

    task automatic wait_grant(input string name);
        int k = 0;
        while (!(bus.busy_o && !bus.wr_en_o) && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) timeout(name);
    endtask

    task automatic check_glog(input string name, input int exp [10], input int n);
        check({name, "_len"}, glog.size(), n);
        for (int i = 0; i < n && i < glog.size(); i++) begin
            check($sformatf("%s_%0d", name, i), glog[i], exp[i]);
        end
    endtask

    int exp2 [10];
    int exp6 [10];

    initial begin
`ifdef MEDIAN_ARB_FIXED_PRIO_EN
        exp2 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        exp6 = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
`else
        exp2 = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
        exp6 = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
`endif
        rem[0] = 0;
        rem[1] = 0;
        dat[0] = 16'h0;
        dat[1] = 16'h0;
        last_addr[0] = 4'h0;
        last_addr[1] = 4'h0;
        bus.rd_done_i = 2'b00;

        // Reset state
        tick(); tick(); tick();
        check("rst_wr_en", bus.wr_en_o, 1'b0);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_frame_rdy", bus.frame_rdy_o, 2'b00);
        check("rst_wr_addr", bus.wr_addr_o, 4'h0);
        rstn_i = 1'b1;
        tick();

        // Single ch0 write: address shown in GRANT, strobe in the following cycle
        dat[0] = 16'hA5A5;
        rem[0] = 1;
        tick();
        check("t1_grant_busy", bus.busy_o, 1'b1);
        check("t1_grant_wr_en", bus.wr_en_o, 1'b0);
        check("t1_grant_data", bus.wr_data_o, 16'hA5A5);
        tick();
        check("t1_wr_en", bus.wr_en_o, 1'b1);
        check("t1_ack", bus.ack_o, 2'b01);
        check("t1_addr", bus.wr_addr_o, 4'b0_000);
        check("t1_data", bus.wr_data_o, 16'hA5A5);
        tick();
        check("t1_idle", bus.busy_o, 1'b0);

        // Both channels requesting continuously
        glog.delete();
        dat[0] = 16'h1000;
        dat[1] = 16'h2000;
        rem[0] = 4;
        rem[1] = 4;
        wait_idle("t2_wait");
        check_glog("t2_order", exp2, 8);
        check("t2_addr0", last_addr[0], 4'b0_100);
        check("t2_addr1", last_addr[1], 4'b1_011);

        // Fill ch0; it blocks while ch1 proceeds; release and wrap
        rem[0] = 3;
        wait_idle("t3_fill");
        check("t3_full", bus.frame_rdy_o, 2'b01);
        check("t3_addr0", last_addr[0], 4'b0_111);
        rem[0] = 1;
        rem[1] = 2;
        wait_ch1_done("t3_ch1");
        check("t3_ch0_blocked", rem[0], 1);
        check("t3_still_full", bus.frame_rdy_o, 2'b01);
        check("t3_addr1", last_addr[1], 4'b1_101);
        bus.rd_done_i = 2'b01;
        tick();
        bus.rd_done_i = 2'b00;
        check("t3_released", bus.frame_rdy_o, 2'b00);
        wait_idle("t3_wrap");
        check("t3_wrap_addr", last_addr[0], 4'b0_000);

        // rd_done on an empty channel during a ch0 write
        rem[0] = 1;
        wait_wr("t4_wr");
        bus.rd_done_i = 2'b10;
        tick();
        bus.rd_done_i = 2'b00;
        wait_idle("t4_wait");
        check("t4_frame_rdy", bus.frame_rdy_o, 2'b00);
        check("t4_addr0", last_addr[0], 4'b0_001);

        // Reset in GRANT: outputs clear at once, no strobe, counters restart
        rem[1] = 1;
        wait_grant("t5_grant");
        rstn_i = 1'b0;
        rem[1] = 0;
        #1;
        check("t5_wr_en", bus.wr_en_o, 1'b0);
        check("t5_ack", bus.ack_o, 2'b00);
        check("t5_busy", bus.busy_o, 1'b0);
        check("t5_addr", bus.wr_addr_o, 4'h0);
        check("t5_data", bus.wr_data_o, 16'h0);
        tick();
        tick();
        rstn_i = 1'b1;
        tick();
        rem[1] = 1;
        wait_idle("t5_ch1");
        check("t5_addr1", last_addr[1], 4'b1_000);
        rem[0] = 1;
        wait_idle("t5_ch0");
        check("t5_addr0", last_addr[0], 4'b0_000);

        // Contention until ch0 fills; ch1 still served; release and resume
        glog.delete();
        dat[0] = 16'h3000;
        dat[1] = 16'h4000;
        rem[0] = 9;
        rem[1] = 3;
        wait_ch1_done_ch0_full("t6_fill");
        check("t6_ch0_left", rem[0], 2);
        check_glog("t6_order", exp6, 10);
        bus.rd_done_i = 2'b01;
        tick();
        bus.rd_done_i = 2'b00;
        wait_idle("t6_resume");
        check("t6_addr0", last_addr[0], 4'b0_001);
        check("t6_frame_rdy", bus.frame_rdy_o, 2'b00);

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/median_wr_arbiter.md
# median_wr_arbiter

Round-robin arbiter that shares one result-memory write port between two median-filter writer channels. Each channel owns one region of 2^DEPTH_LOG2 words. The block places each word at the channel's next address and raises a per-channel frame-ready flag when the region is full. A full channel is blocked until the PicoBlaze readout side acknowledges that it has consumed the frame. The block sits between the median writer FSMs and the shared result RAM / PicoBlaze input port.

## Interface
Parameters:
- DW, 16, data word width
- DEPTH_LOG2, 3, log2 of words per channel region (8 words)

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- req_i  in  2  per-channel write request; level, held until ack
- data_i  in  2×DW  per-channel write data; stable while req_i is high
- ack_o  out  2  per-channel one-cycle grant/accept pulse
- wr_en_o  out  1  one-cycle write strobe to result RAM
- wr_addr_o  out  DEPTH_LOG2+1  {channel, word index}
- wr_data_o  out  DW  write data
- frame_rdy_o  out  2  level; the channel region holds a complete frame
- rd_done_i  in  2  one-cycle pulse from the reader; frees the channel region
- busy_o  out  1  high in any state other than IDLE

## Operation
- State machine IDLE → GRANT → WRITE → IDLE. Encoding is a 2-bit enum.
- Eligibility: channel c is eligible when req_i[c]=1 and frame_rdy_o[c]=0.
- IDLE behaviour:
  - With no eligible channel, the block stays in IDLE.
  - Otherwise it selects the winner by round-robin. The last_grant pointer is reset to 1, so channel 0 wins the first tie.
  - It latches winner, data_i[winner] and {winner, cnt[winner]}, then goes to GRANT.
- GRANT: drives wr_addr_o and wr_data_o from the latches, with wr_en_o=0. Goes to WRITE.
- WRITE actions:
  - wr_en_o=1 and ack_o[winner]=1, for exactly this cycle.
  - cnt[winner] increments. last_grant is set to winner.
  - If cnt[winner] was 2^DEPTH_LOG2−1, it wraps to 0 and frame_rdy_o[winner] is set at the end of the cycle.
  - Next state is IDLE.
- Requester rule: drop req_i on the edge where ack_o is seen high, or keep it high for the next word with new data.
- rd_done_i[c] clears frame_rdy_o[c]. It is ignored when frame_rdy_o[c]=0.
- A blocked (full) channel never stalls the other channel.
- Counter width is DEPTH_LOG2. Wrap-around happens by natural overflow.

## Timing
- Reset values: state=IDLE, ack_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, frame_rdy_o=0, busy_o=0, cnt=0, last_grant=1.
- Latency: with req_i sampled high in IDLE at edge N, wr_en_o and ack_o are high during cycle N+2 (edges N+1..N+2). The block is back in IDLE at edge N+3.
- Throughput: one write per 3 cycles.
- wr_addr_o and wr_data_o are valid from GRANT through WRITE. They hold their last value in IDLE.
- Simultaneous rd_done_i[c] and the final write of channel c cannot occur, because the channel is ineligible while full. If both events land in the same cycle for a freshly full channel, the set wins.
- rd_done_i on one channel in the same cycle as a write on the other channel: both take effect.
- A req_i drop during GRANT is a protocol violation. The write still completes, and an assertion flags it.
- Reset mid-operation aborts any pending write and clears all counters and flags. A frame that was partly written is discarded.
- Assertions:
  - ack_o is one-hot or zero.
  - wr_en_o equals |ack_o.
  - No ack_o is issued to a channel with frame_rdy_o set.

## Configuration
- MEDIAN_ARB_FIXED_PRIO_EN defined: fixed priority, channel 0 always wins a tie, and last_grant is not implemented.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both modes.

## Structure
- Package median_arb_pkg holds:
  - the state_t enum (IDLE, GRANT, WRITE)
  - NCH=2
  - the default DW and DEPTH_LOG2 localparams
- One natural sub-module, rr_arb2: a combinational 2-way round-robin picker with a registered pointer update input. Under MEDIAN_ARB_FIXED_PRIO_EN it degenerates to a priority encoder.

## Test plan
- Reset, then ch0 req with data 16'hA5A5 → ack_o[0] and wr_en_o in the 3rd cycle, wr_addr_o=4'b0_000, wr_data_o=16'hA5A5.
- Both channels requesting continuously (round-robin build) → grants alternate 0,1,0,1, and each channel's address increments 0..7.
- Ch0 writes 8 words → frame_rdy_o[0]=1 and ch0 is blocked while ch1 continues. A rd_done_i[0] pulse clears the flag, and the next ch0 write goes to address 0 (wrap-around).
- rd_done_i[1] while frame_rdy_o[1]=0 → no state change. Same cycle as a ch0 write → the ch0 write completes normally.
- Assert rstn_i low in the GRANT state → all outputs are 0 immediately and no wr_en_o pulse occurs. The counters restart at 0 afterwards.
- With MEDIAN_ARB_FIXED_PRIO_EN and both channels requesting → ch0 is granted every time until it is full, then ch1 is served.
